// File: rtl/iter_div_pkg.sv
// iter_div_pkg: widths, state encoding and the conditional-negate helper
// shared by the iterative radix-2 restoring divider.
package iter_div_pkg;

    // Datapath width and iteration counter width (32 steps, counted 31..0)
    localparam int DIV_W     = 32;
    localparam int DIV_CNT_W = 5;

    // Counter value loaded on start so that CALC lasts exactly DIV_W cycles
    localparam logic [DIV_CNT_W-1:0] DIV_LAST_CNT = DIV_CNT_W'(DIV_W - 1);

    // Quotient returned for any divide by zero, regardless of signedness
    localparam logic [DIV_W-1:0] DIV_ZERO_QUO = 32'hFFFF_FFFF;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    // Two's-complement negate when neg is set; used both to take operand
    // magnitudes on entry and to restore result signs on exit.
    function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] value,
                                                  input logic             neg);
        return neg ? -value : value;
    endfunction

endpackage

// File: rtl/iter_div.sv
// iter_div: multi-cycle radix-2 restoring divider, responder end of the EX
// divide handshake. One start per 34 cycles; the result appears as a single
// dout_tvalid pulse 33 cycles after the accepting edge and is then held.
module iter_div
    import iter_div_pkg::*;
#(
    parameter bit SIGNED = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_axis_dividend_tvalid,
    output logic               s_axis_dividend_tready,
    input  logic [DIV_W-1:0]   s_axis_dividend_tdata,
    input  logic               s_axis_divisor_tvalid,
    output logic               s_axis_divisor_tready,
    input  logic [DIV_W-1:0]   s_axis_divisor_tdata,
    output logic               m_axis_dout_tvalid,
    output logic [2*DIV_W-1:0] m_axis_dout_tdata
);

    div_state_e           state;
    div_state_e           state_next;
    logic [DIV_CNT_W-1:0] cnt;
    logic [DIV_W-1:0]     quo;
    logic [DIV_W-1:0]     rem;
    logic [DIV_W-1:0]     dvs;
    logic                 qneg;
    logic                 rneg;
    logic                 div_zero;

    logic                 start;
    logic                 last_step;
    logic                 dvd_neg;
    logic                 dvs_neg;
    logic                 dvs_zero;
    logic [DIV_W:0]       rem_shift;
    logic [DIV_W:0]       rem_diff;
    logic [DIV_W-1:0]     quo_step;
    logic [DIV_W-1:0]     rem_step;
    logic [DIV_W-1:0]     res_quo;
    logic [DIV_W-1:0]     res_rem;

    // Controller state register; reset aborts any operation in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: IDLE waits for both operands, CALC runs 32 steps, DONE is one cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Controller outputs: a start is both treadys together, and the final CALC step
    always_comb begin
        start     = (state == IDLE) & s_axis_dividend_tvalid & s_axis_divisor_tvalid;
        last_step = (state == CALC) && (cnt == '0);
    end

    assign s_axis_dividend_tready = start;
    assign s_axis_divisor_tready  = start;

    // Operand classification at the start cycle: signs (signed mode only) and zero divisor
    always_comb begin
        dvd_neg  = SIGNED && s_axis_dividend_tdata[DIV_W-1];
        dvs_neg  = SIGNED && s_axis_divisor_tdata[DIV_W-1];
        dvs_zero = (s_axis_divisor_tdata == '0);
    end

    // One restoring step plus the sign fixup of the values that step produces;
    // the 33-bit subtract's borrow doubles as the compare result.
    always_comb begin
        rem_shift = {rem, quo[DIV_W-1]};
        rem_diff  = rem_shift - {1'b0, dvs};
        quo_step  = {quo[DIV_W-2:0], ~rem_diff[DIV_W]};
        rem_step  = rem_diff[DIV_W] ? rem_shift[DIV_W-1:0] : rem_diff[DIV_W-1:0];
        res_quo   = div_zero ? DIV_ZERO_QUO : cond_neg(quo_step, qneg);
        res_rem   = cond_neg(rem_step, rneg);
    end

    // Operand latch on start and shift/subtract iteration during CALC.
    // A zero divisor keeps the raw dividend so the remainder comes out untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
            div_zero <= 1'b0;
        end else if (start) begin
            cnt <= DIV_LAST_CNT;
            rem <= '0;
            if (dvs_zero) begin
                quo      <= s_axis_dividend_tdata;
                dvs      <= '0;
                qneg     <= 1'b0;
                rneg     <= 1'b0;
                div_zero <= 1'b1;
            end else begin
                quo      <= cond_neg(s_axis_dividend_tdata, dvd_neg);
                dvs      <= cond_neg(s_axis_divisor_tdata, dvs_neg);
                qneg     <= dvd_neg ^ dvs_neg;
                rneg     <= dvd_neg;
                div_zero <= 1'b0;
            end
        end else if (state == CALC) begin
            quo <= quo_step;
            rem <= rem_step;
            cnt <= cnt - DIV_CNT_W'(1);
        end
    end

    // Result register: loaded on the edge entering DONE so the pulse and data
    // coincide in the DONE cycle; the data then holds until the next result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_dout_tvalid <= 1'b0;
            m_axis_dout_tdata  <= '0;
        end else begin
            m_axis_dout_tvalid <= last_step;
            if (last_step) begin
                m_axis_dout_tdata <= {res_quo, res_rem};
            end
        end
    end

endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div: directed checks of the unsigned and signed divider instances
// sharing one stimulus stream.
module tb_iter_div;

    logic        clk;
    logic        rst;
    logic        dvd_valid;
    logic        dvs_valid;
    logic [31:0] dvd_data;
    logic [31:0] dvs_data;

    logic        dvd_ready_u, dvs_ready_u, dout_valid_u;
    logic [63:0] dout_data_u;
    logic        dvd_ready_s, dvs_ready_s, dout_valid_s;
    logic [63:0] dout_data_s;

    int checks;
    int failures;

    iter_div #(.SIGNED(1'b0)) u_div_u (
        .clk                    (clk),
        .rst                    (rst),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_ready_u),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_ready_u),
        .s_axis_divisor_tdata   (dvs_data),
        .m_axis_dout_tvalid     (dout_valid_u),
        .m_axis_dout_tdata      (dout_data_u)
    );

    iter_div #(.SIGNED(1'b1)) u_div_s (
        .clk                    (clk),
        .rst                    (rst),
        .s_axis_dividend_tvalid (dvd_valid),
        .s_axis_dividend_tready (dvd_ready_s),
        .s_axis_dividend_tdata  (dvd_data),
        .s_axis_divisor_tvalid  (dvs_valid),
        .s_axis_divisor_tready  (dvs_ready_s),
        .s_axis_divisor_tdata   (dvs_data),
        .m_axis_dout_tvalid     (dout_valid_s),
        .m_axis_dout_tdata      (dout_data_s)
    );

    // 10-unit clock; stimulus is driven on the falling edge
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one operand pair in the current cycle, then watch 40 cycles for
    // the busy window, the single pulse at +33, its data, and the held value.
    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp_u, input logic [63:0] exp_s);
        int pulses_u, pulses_s, k_u, k_s, busy_viol;
        logic [63:0] got_u, got_s;
        pulses_u = 0; pulses_s = 0; k_u = -1; k_s = -1; busy_viol = 0;
        got_u = '0; got_s = '0;
        @(negedge clk);
        dvd_data = a; dvs_data = b; dvd_valid = 1'b1; dvs_valid = 1'b1;
        #1;
        checks++;
        if ({dvd_ready_u, dvs_ready_u, dvd_ready_s, dvs_ready_s} !== 4'hF) begin
            failures++;
            $display("[TB] FAIL %s_accept: treadys=%b required 1111", name,
                     {dvd_ready_u, dvs_ready_u, dvd_ready_s, dvs_ready_s});
        end
        @(negedge clk);
        dvd_valid = 1'b0; dvs_valid = 1'b0;
        dvd_data = 32'hDEAD_BEEF; dvs_data = 32'h0BAD_F00D;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (k <= 33 && (dvd_ready_u || dvs_ready_u || dvd_ready_s || dvs_ready_s))
                busy_viol++;
            if (dout_valid_u) begin pulses_u++; k_u = k; got_u = dout_data_u; end
            if (dout_valid_s) begin pulses_s++; k_s = k; got_s = dout_data_s; end
            @(negedge clk);
        end
        checks++;
        if (busy_viol !== 0) begin
            failures++;
            $display("[TB] FAIL %s_busy: tready high in %0d busy cycles, required 0", name, busy_viol);
        end
        checks++;
        if (pulses_u !== 1 || k_u !== 33) begin
            failures++;
            $display("[TB] FAIL %s_pulse_u: %0d pulses last at +%0d, required 1 at +33", name, pulses_u, k_u);
        end
        checks++;
        if (pulses_s !== 1 || k_s !== 33) begin
            failures++;
            $display("[TB] FAIL %s_pulse_s: %0d pulses last at +%0d, required 1 at +33", name, pulses_s, k_s);
        end
        checks++;
        if (got_u !== exp_u) begin
            failures++;
            $display("[TB] FAIL %s_data_u: got %h required %h", name, got_u, exp_u);
        end
        checks++;
        if (got_s !== exp_s) begin
            failures++;
            $display("[TB] FAIL %s_data_s: got %h required %h", name, got_s, exp_s);
        end
        checks++;
        if (dout_data_u !== exp_u || dout_data_s !== exp_s) begin
            failures++;
            $display("[TB] FAIL %s_hold: got %h / %h required %h / %h", name,
                     dout_data_u, dout_data_s, exp_u, exp_s);
        end
    endtask

    // Power-on reset: all outputs low while held, design idle after release
    task automatic test_reset();
        rst = 1'b1; dvd_valid = 1'b0; dvs_valid = 1'b0;
        dvd_data = '0; dvs_data = '0;
        #1;
        checks++;
        if ({dout_valid_u, dout_valid_s, dvd_ready_u, dvs_ready_u, dvd_ready_s, dvs_ready_s} !== 6'b0
            || dout_data_u !== 64'd0 || dout_data_s !== 64'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: valid=%b%b data=%h/%h required zeros",
                     dout_valid_u, dout_valid_s, dout_data_u, dout_data_s);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (dout_valid_u !== 1'b0 || dout_valid_s !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle: dout_tvalid=%b%b required 00", dout_valid_u, dout_valid_s);
        end
    endtask

    task automatic test_basic();
        run_op("d100_7", 32'd100, 32'd7, {32'd14, 32'd2}, {32'd14, 32'd2});
    endtask

    task automatic test_signed();
        run_op("n7_2",   32'hFFFF_FFF9, 32'd2,        {32'h7FFF_FFFC, 32'd1},        {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        run_op("p7_n2",  32'd7,         32'hFFFF_FFFE, {32'd0, 32'd7},               {32'hFFFF_FFFD, 32'd1});
        run_op("n100_7", 32'hFFFF_FF9C, 32'd7,        {32'h2492_4916, 32'd2},        {32'hFFFF_FFF2, 32'hFFFF_FFFE});
        run_op("n2_n1",  32'hFFFF_FFFE, 32'hFFFF_FFFF, {32'd0, 32'hFFFF_FFFE},       {32'd2, 32'd0});
    endtask

    task automatic test_boundaries();
        run_op("ovf",    32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000},       {32'h8000_0000, 32'd0});
        run_op("max_1",  32'hFFFF_FFFF, 32'd1,        {32'hFFFF_FFFF, 32'd0},        {32'hFFFF_FFFF, 32'd0});
        run_op("dvsmin", 32'hFFFF_FFFF, 32'h8000_0000, {32'd1, 32'h7FFF_FFFF},       {32'd0, 32'hFFFF_FFFF});
    endtask

    task automatic test_div_zero();
        run_op("dz",     32'h0000_1234, 32'd0, {32'hFFFF_FFFF, 32'h0000_1234}, {32'hFFFF_FFFF, 32'h0000_1234});
        run_op("dz_neg", 32'hFFFF_FFFB, 32'd0, {32'hFFFF_FFFF, 32'hFFFF_FFFB}, {32'hFFFF_FFFF, 32'hFFFF_FFFB});
    endtask

    // Both tvalids held high: accepts at T and T+34, pulses at +33 and +67
    task automatic test_back_to_back();
        int ready_cnt, ready_k, pulses, pk1, pk2;
        logic [63:0] d1_u, d1_s, d2_u, d2_s;
        ready_cnt = 0; ready_k = -1; pulses = 0; pk1 = -1; pk2 = -1;
        d1_u = '0; d1_s = '0; d2_u = '0; d2_s = '0;
        @(negedge clk);
        dvd_data = 32'd1_000_000; dvs_data = 32'd1000; dvd_valid = 1'b1; dvs_valid = 1'b1;
        #1;
        checks++;
        if (dvd_ready_u !== 1'b1 || dvd_ready_s !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_first_accept: tready=%b%b required 11", dvd_ready_u, dvd_ready_s);
        end
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            if (k == 34) begin dvd_data = 32'hFFFF_FF9C; dvs_data = 32'd7; end
            if (k == 35) begin dvd_valid = 1'b0; dvs_valid = 1'b0; end
            #1;
            if (dvd_ready_u || dvs_ready_s) begin ready_cnt++; ready_k = k; end
            if (dout_valid_u) begin
                pulses++;
                if (pk1 < 0) begin pk1 = k; d1_u = dout_data_u; d1_s = dout_data_s; end
                else begin pk2 = k; d2_u = dout_data_u; d2_s = dout_data_s; end
            end
        end
        checks++;
        if (ready_cnt !== 1 || ready_k !== 34) begin
            failures++;
            $display("[TB] FAIL b2b_second_accept: %0d ready cycles last at +%0d, required 1 at +34",
                     ready_cnt, ready_k);
        end
        checks++;
        if (pulses !== 2 || pk1 !== 33 || pk2 !== 67) begin
            failures++;
            $display("[TB] FAIL b2b_pulses: %0d pulses at +%0d,+%0d required 2 at +33,+67", pulses, pk1, pk2);
        end
        checks++;
        if (d1_u !== {32'd1000, 32'd0} || d1_s !== {32'd1000, 32'd0}) begin
            failures++;
            $display("[TB] FAIL b2b_data1: got %h / %h required %h", d1_u, d1_s, {32'd1000, 32'd0});
        end
        checks++;
        if (d2_u !== {32'h2492_4916, 32'd2} || d2_s !== {32'hFFFF_FFF2, 32'hFFFF_FFFE}) begin
            failures++;
            $display("[TB] FAIL b2b_data2: got %h / %h required %h / %h", d2_u, d2_s,
                     {32'h2492_4916, 32'd2}, {32'hFFFF_FFF2, 32'hFFFF_FFFE});
        end
    endtask

    // A lone tvalid in IDLE must not start anything
    task automatic test_single_valid();
        int viol, pulses;
        viol = 0; pulses = 0;
        @(negedge clk);
        dvd_data = 32'd50; dvs_data = 32'd5; dvd_valid = 1'b1; dvs_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (k == 20) begin dvd_valid = 1'b0; dvs_valid = 1'b1; end
            #1;
            if (dvd_ready_u || dvs_ready_u || dvd_ready_s || dvs_ready_s) viol++;
            if (dout_valid_u || dout_valid_s) pulses++;
            @(negedge clk);
        end
        dvs_valid = 1'b0;
        checks++;
        if (viol !== 0) begin
            failures++;
            $display("[TB] FAIL single_valid_ready: %0d cycles with tready, required 0", viol);
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("[TB] FAIL single_valid_pulse: %0d pulses, required 0", pulses);
        end
    endtask

    // Asynchronous reset at T+10 aborts the op: immediate zeros, no pulse
    task automatic test_reset_mid_op();
        int pulses;
        pulses = 0;
        @(negedge clk);
        dvd_data = 32'd999; dvs_data = 32'd4; dvd_valid = 1'b1; dvs_valid = 1'b1;
        @(negedge clk);
        dvd_valid = 1'b0; dvs_valid = 1'b0;
        repeat (9) @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (dout_valid_u !== 1'b0 || dout_valid_s !== 1'b0
            || dout_data_u !== 64'd0 || dout_data_s !== 64'd0) begin
            failures++;
            $display("[TB] FAIL async_reset_outputs: valid=%b%b data=%h/%h required zeros",
                     dout_valid_u, dout_valid_s, dout_data_u, dout_data_s);
        end
        #10;
        rst = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (dout_valid_u || dout_valid_s) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("[TB] FAIL async_reset_no_pulse: %0d pulses, required 0", pulses);
        end
        run_op("post_rst", 32'd1000, 32'd3, {32'd333, 32'd1}, {32'd333, 32'd1});
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_signed();
        test_boundaries();
        test_div_zero();
        test_back_to_back();
        test_single_valid();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
